// File: rtl/uart_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_frame_scheduler
// Purpose  : Synchronizes two player status bytes and detects their changes.
//            Schedules change/heartbeat frames onto one UART through a
//            valid/ready handshake. Arbitration is urgent-first, then
//            round-robin. A minimum idle gap follows every accepted frame.
// Revision : 1.0  initial release
// ============================================================================
module uart_frame_scheduler #(
    parameter int HEARTBEAT_CYCLES = 1000000,
    parameter int GAP_CYCLES       = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  p0_data,
    input  logic [7:0]  p1_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_tag,
    output logic [15:0] frames_sent
);

    localparam int c_HB_W  = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_HB_W-1:0]  c_HB_LAST  = c_HB_W'(HEARTBEAT_CYCLES - 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = (GAP_CYCLES > 0) ? c_GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    logic [1:0][7:0]     s1_q, s2_q, shadow_q;
    logic [1:0]          hb_q;
    logic [c_HB_W-1:0]   hb_cnt_q;
    logic [c_GAP_W-1:0]  gap_cnt_q;
    state_t              state_q;
    logic                rr_q;
    logic                tx_valid_q, tx_tag_q;
    logic [7:0]          tx_data_q;
    logic [15:0]         frames_q;

    logic [1:0]          w_pend, w_urg;
    logic                w_grant, w_hb_tick, w_accept;

    assign w_hb_tick = (hb_cnt_q == c_HB_LAST);
    assign w_accept  = tx_valid_q & tx_ready;

    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign tx_tag      = tx_tag_q;
    assign frames_sent = frames_q;

    // Two-flop synchronizers; only the second stage feeds the logic
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= {p1_data, p0_data};
            s2_q <= s1_q;
        end
    end

    // Free-running heartbeat counter, wraps at the terminal count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hb_cnt_q <= '0;
        end else if (w_hb_tick) begin
            hb_cnt_q <= '0;
        end else begin
            hb_cnt_q <= hb_cnt_q + c_HB_W'(1);
        end
    end

    // Sticky heartbeat flags; a tick overrides a same-edge acceptance clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hb_q <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_hb_tick) begin
                    hb_q[i] <= 1'b1;
                end else if (w_accept && (tx_tag_q == i[0])) begin
                    hb_q[i] <= 1'b0;
                end
            end
        end
    end

    // Shadow of the last accepted byte per player and the accepted-frame count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '0;
            frames_q <= '0;
        end else if (w_accept) begin
            shadow_q[tx_tag_q] <= tx_data_q;
            frames_q           <= frames_q + 16'd1;
        end
    end

    // Pending/urgent detection and the urgent-first, round-robin grant choice
    always_comb begin
        w_pend  = '0;
        w_urg   = '0;
        w_grant = 1'b0;
        for (int i = 0; i < 2; i++) begin
            w_pend[i] = (s2_q[i] != shadow_q[i]) | hb_q[i];
            w_urg[i]  = w_pend[i] & s2_q[i][7];
        end
        if (w_urg[0] ^ w_urg[1]) begin
            w_grant = w_urg[1];
        end else if (w_urg[0] | (w_pend[0] & w_pend[1])) begin
            w_grant = rr_q;
        end else begin
            w_grant = w_pend[1];
        end
    end

    // Frame FSM: grant in IDLE, hold the offer in SEND, enforce spacing in GAP
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            gap_cnt_q  <= '0;
            rr_q       <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_tag_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|w_pend) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= s2_q[w_grant];
                        tx_tag_q   <= w_grant;
                        rr_q       <= ~w_grant;
                        state_q    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        if (GAP_CYCLES > 0) begin
                            gap_cnt_q <= c_GAP_LOAD;
                            state_q   <= S_GAP;
                        end else begin
                            state_q   <= S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == '0) begin
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - c_GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_frame_scheduler
// Purpose  : Self-checking bench for uart_frame_scheduler against a
//            transaction-timed reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_frame_scheduler;

    localparam int HB  = 100;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  p0_data = 8'h00, p1_data = 8'h00;
    logic        tx_ready = 1'b0;
    logic        tx_valid, tx_tag;
    logic [7:0]  tx_data;
    logic [15:0] frames_sent;

    int vectors = 0;
    int miscompares = 0;

    uart_frame_scheduler #(.HEARTBEAT_CYCLES(HB), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .p0_data(p0_data), .p1_data(p1_data),
        .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_tag(tx_tag), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    // Reference model: edges are numbered from 1 after reset release.
    logic [7:0]  h0 [0:8191];
    logic [7:0]  h1 [0:8191];
    int          mk;
    int          m_free;
    logic        m_offer, m_tag, m_rr;
    logic [7:0]  m_data;
    logic [7:0]  m_shadow [2];
    logic        m_hb [2];
    logic [15:0] m_count;
    logic [8:0]  fq [$];

    task automatic model_reset();
        mk = 1; m_free = 1; m_offer = 0; m_tag = 0; m_rr = 0; m_data = 8'h00;
        m_shadow[0] = 8'h00; m_shadow[1] = 8'h00; m_hb[0] = 0; m_hb[1] = 0;
        m_count = 16'd0;
    endtask

    task automatic model_edge(input logic [7:0] a, input logic [7:0] b, input logic r);
        logic [7:0] s2v [2];
        logic pend [2];
        logic urg [2];
        logic acc, tick, gok, g;
        h0[mk] = a; h1[mk] = b;
        // the byte seen downstream at edge k is what the pins held at edge k-2
        s2v[0] = (mk >= 3) ? h0[mk-2] : 8'h00;
        s2v[1] = (mk >= 3) ? h1[mk-2] : 8'h00;
        tick = (((mk - 1) % HB) == HB - 1);
        for (int x = 0; x < 2; x++) begin
            pend[x] = (s2v[x] != m_shadow[x]) || m_hb[x];
            urg[x]  = pend[x] && s2v[x][7];
        end
        acc = m_offer && r;
        gok = !m_offer && (mk >= m_free) && (pend[0] || pend[1]);
        if (urg[0] != urg[1])                    g = urg[1];
        else if (urg[0] || (pend[0] && pend[1])) g = m_rr;
        else                                     g = pend[1];
        if (acc) begin
            m_shadow[m_tag] = m_data;
            m_hb[m_tag] = 0;
            m_count = m_count + 16'd1;
            m_offer = 0;
            m_free = mk + GAP + 1;
        end
        if (tick) begin
            m_hb[0] = 1; m_hb[1] = 1;
        end
        if (gok) begin
            m_offer = 1; m_data = s2v[g]; m_tag = g; m_rr = ~g;
        end
        mk++;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic r);
        p0_data = a; p1_data = b; tx_ready = r;
        if (tx_valid && r) fq.push_back({tx_tag, tx_data});
        @(posedge clk);
        model_edge(a, b, r);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [7:0] a, input logic [7:0] b, input logic r);
        rst = 1'b0; p0_data = a; p1_data = b; tx_ready = r;
        model_reset();
        fq.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if ({tx_valid, tx_tag, tx_data, frames_sent} !== 26'd0) begin
            miscompares++;
            $display("FAIL reset_values got v=%b t=%b d=%h n=%0d exp all zero", tx_valid, tx_tag, tx_data, frames_sent);
        end
        do_reset(8'h05, 8'h05, 1'b1);
        for (int i = 1; i <= 30; i++) begin
            step(8'h05, 8'h05, 1'b1);
            if (i == 3) begin
                vectors++;
                if ({tx_valid, tx_tag, tx_data} !== {1'b1, 1'b0, 8'h05}) begin
                    miscompares++;
                    $display("FAIL first_offer_edge3 got v=%b t=%b d=%h exp v=1 t=0 d=05", tx_valid, tx_tag, tx_data);
                end
            end
            vectors++;
            if ({tx_valid, tx_tag, tx_data, frames_sent} !== {m_offer, m_tag, m_data, m_count}) begin
                miscompares++;
                $display("FAIL reset_seq edge%0d got v=%b t=%b d=%h n=%0d exp v=%b t=%b d=%h n=%0d",
                         i, tx_valid, tx_tag, tx_data, frames_sent, m_offer, m_tag, m_data, m_count);
            end
        end
        vectors++;
        if (fq.size() != 2 || fq[0] !== 9'h005 || fq[1] !== 9'h105 || frames_sent !== 16'd2) begin
            miscompares++;
            $display("FAIL reset_frames got %0d frames, count %0d exp tag0/05 then tag1/05, count 2", fq.size(), frames_sent);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] a;
        do_reset(8'h05, 8'h00, 1'b0);
        for (int i = 0; i < 80; i++) begin
            a = (i < 10) ? 8'h05 : ((i < 30) ? 8'h06 : 8'h07);
            if (i >= 3 && i < 50) begin
                vectors++;
                if ({tx_valid, tx_tag, tx_data} !== {1'b1, 1'b0, 8'h05}) begin
                    miscompares++;
                    $display("FAIL bp_hold cyc%0d got v=%b t=%b d=%h exp v=1 t=0 d=05", i, tx_valid, tx_tag, tx_data);
                end
            end
            step(a, 8'h00, i >= 50);
            vectors++;
            if ({tx_valid, tx_tag, tx_data, frames_sent} !== {m_offer, m_tag, m_data, m_count}) begin
                miscompares++;
                $display("FAIL bp_seq cyc%0d got v=%b t=%b d=%h n=%0d exp v=%b t=%b d=%h n=%0d",
                         i, tx_valid, tx_tag, tx_data, frames_sent, m_offer, m_tag, m_data, m_count);
            end
        end
        vectors++;
        if (fq.size() != 2 || fq[0] !== 9'h005 || fq[1] !== 9'h007) begin
            miscompares++;
            $display("FAIL bp_frames got %0d frames first=%h last=%h exp 2 frames 005 then 007",
                     fq.size(), (fq.size() > 0) ? fq[0] : 9'h0, (fq.size() > 0) ? fq[fq.size()-1] : 9'h0);
        end
    endtask

    task automatic test_urgent();
        do_reset(8'h05, 8'h85, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            step(8'h05, 8'h85, 1'b1);
            if (i == 3) begin
                vectors++;
                if ({tx_valid, tx_tag, tx_data} !== {1'b1, 1'b1, 8'h85}) begin
                    miscompares++;
                    $display("FAIL urgent_first got v=%b t=%b d=%h exp v=1 t=1 d=85", tx_valid, tx_tag, tx_data);
                end
            end
            vectors++;
            if ({tx_valid, tx_tag, tx_data, frames_sent} !== {m_offer, m_tag, m_data, m_count}) begin
                miscompares++;
                $display("FAIL urgent_seq edge%0d got v=%b t=%b d=%h n=%0d exp v=%b t=%b d=%h n=%0d",
                         i, tx_valid, tx_tag, tx_data, frames_sent, m_offer, m_tag, m_data, m_count);
            end
        end
        vectors++;
        if (fq.size() != 2 || fq[0] !== 9'h185 || fq[1] !== 9'h005) begin
            miscompares++;
            $display("FAIL urgent_frames got %0d frames first=%h exp 185 then 005", fq.size(), (fq.size() > 0) ? fq[0] : 9'h0);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] c;
        do_reset(8'h00, 8'h00, 1'b1);
        for (int i = 1; i <= 60; i++) begin
            c = 8'(i);
            step({1'b0, c[6:0]}, {1'b0, c[6:0] ^ 7'h55}, 1'b1);
            vectors++;
            if ({tx_valid, tx_tag, tx_data, frames_sent} !== {m_offer, m_tag, m_data, m_count}) begin
                miscompares++;
                $display("FAIL rr_seq edge%0d got v=%b t=%b d=%h n=%0d exp v=%b t=%b d=%h n=%0d",
                         i, tx_valid, tx_tag, tx_data, frames_sent, m_offer, m_tag, m_data, m_count);
            end
        end
        for (int j = 0; j < 8; j++) begin
            vectors++;
            if (j >= fq.size() || fq[j][8] !== j[0]) begin
                miscompares++;
                $display("FAIL rr_alternate frame%0d got tag=%b exp tag=%0d", j, (j < fq.size()) ? fq[j][8] : 1'bx, j % 2);
            end
        end
    endtask

    task automatic test_heartbeat();
        do_reset(8'h12, 8'h34, 1'b1);
        for (int i = 1; i <= 320; i++) begin
            step(8'h12, 8'h34, 1'b1);
            vectors++;
            if ({tx_valid, tx_tag, tx_data, frames_sent} !== {m_offer, m_tag, m_data, m_count}) begin
                miscompares++;
                $display("FAIL hb_seq edge%0d got v=%b t=%b d=%h n=%0d exp v=%b t=%b d=%h n=%0d",
                         i, tx_valid, tx_tag, tx_data, frames_sent, m_offer, m_tag, m_data, m_count);
            end
        end
        vectors++;
        if (fq.size() != 8 || frames_sent !== 16'd8) begin
            miscompares++;
            $display("FAIL hb_count got %0d frames, count %0d exp 8", fq.size(), frames_sent);
        end
        foreach (fq[j]) begin
            vectors++;
            if (fq[j][7:0] !== (fq[j][8] ? 8'h34 : 8'h12) || fq[j][8] !== j[0]) begin
                miscompares++;
                $display("FAIL hb_data frame%0d got %h exp tag %0d data %h", j, fq[j], j % 2, (j % 2) ? 8'h34 : 8'h12);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] a, b;
        a = 8'h00; b = 8'h00;
        do_reset(a, b, 1'b0);
        for (int i = 1; i <= 2000; i++) begin
            if ($urandom_range(0, 7) == 0) a = 8'($urandom);
            if ($urandom_range(0, 7) == 0) b = 8'($urandom);
            step(a, b, $urandom_range(0, 3) != 0);
            vectors++;
            if ({tx_valid, tx_tag, tx_data, frames_sent} !== {m_offer, m_tag, m_data, m_count}) begin
                miscompares++;
                $display("FAIL rand_seq edge%0d got v=%b t=%b d=%h n=%0d exp v=%b t=%b d=%h n=%0d",
                         i, tx_valid, tx_tag, tx_data, frames_sent, m_offer, m_tag, m_data, m_count);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset(8'h05, 8'h00, 1'b1);
        repeat (8) step(8'h05, 8'h00, 1'b1);
        repeat (6) step(8'h09, 8'h00, 1'b0);
        vectors++;
        if ({tx_valid, tx_data, frames_sent} !== {1'b1, 8'h09, 16'd1}) begin
            miscompares++;
            $display("FAIL arst_setup got v=%b d=%h n=%0d exp v=1 d=09 n=1", tx_valid, tx_data, frames_sent);
        end
        #1 rst = 1'b0;
        #1;
        vectors++;
        if ({tx_valid, frames_sent} !== 17'd0) begin
            miscompares++;
            $display("FAIL arst_immediate got v=%b n=%0d exp v=0 n=0", tx_valid, frames_sent);
        end
    endtask

    initial begin
        test_reset();
        test_backpressure();
        test_urgent();
        test_round_robin();
        test_heartbeat();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_frame_scheduler.md
# uart_frame_scheduler

Sits between the two player input controllers and the shared UART transmitter. Each player controller produces an 8-bit status byte: bit 7 = reset, bits 5:4 = projectile, bits 3:0 = lane. This block synchronizes both bytes and detects changes. It schedules frames onto the single UART through a valid/ready handshake using urgent-first, round-robin arbitration. It adds a periodic heartbeat resend and a minimum inter-frame gap.

## Interface
Parameters:
- HEARTBEAT_CYCLES, default 1000000; period of forced resend of both players; must be ≥ 2.
- GAP_CYCLES, default 16; idle cycles enforced after each accepted frame; 0 allowed (no gap).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst  in  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion is synchronous to clk.
- p0_data  in  8  player 0 status byte; asynchronous to clk.
- p1_data  in  8  player 1 status byte; asynchronous to clk.
- tx_ready  in  1  UART transmitter can accept a byte this cycle.
- tx_valid  out  1  frame offered.
- tx_data  out  8  frame byte.
- tx_tag  out  1  source player of tx_data (0/1).
- frames_sent  out  16  count of accepted frames; wraps 0xFFFF→0x0000.

## Operation
- Input sync: each pX_data passes through a 2-flop synchronizer (s1, s2). Only s2 is used downstream.
- Shadow: shadow_X holds the last byte accepted for player X. Reset value is 8'h00.
- Change: chg_X = (s2_X != shadow_X).
- Heartbeat: a free-running counter runs 0..HEARTBEAT_CYCLES-1. At the terminal count it sets hb_X for both players.
  - Each hb_X is a sticky flag, cleared only when a frame for X is accepted.
  - A tick that finds a flag already set has no additional effect.
- Pending: pend_X = chg_X | hb_X.
- Urgent: urg_X = pend_X & s2_X[7].
- Arbitration (IDLE only):
  - If exactly one urg_X is set, grant X.
  - Else if both urg_X are set, or neither is set but both pend_X are set, grant rr_ptr.
  - Else grant the single pending player.
  - After any grant, rr_ptr ← other player. rr_ptr resets to 0.
- FSM states: IDLE, SEND, GAP. Reset state is IDLE.
  - IDLE → SEND on any pend_X. On that edge: tx_data ← s2_grant, tx_tag ← grant, tx_valid ← 1.
  - SEND: tx_data and tx_tag are held stable until acceptance. Later changes of s2 are not reflected in the offered byte.
  - On acceptance (tx_valid & tx_ready at an edge), all of the following happen on that edge:
    - shadow_tag ← tx_data
    - clear hb_tag
    - frames_sent + 1
    - tx_valid ← 0
    - move to GAP if GAP_CYCLES > 0, otherwise to IDLE.
  - GAP: a counter loads GAP_CYCLES-1 on entry and decrements. At 0 the FSM moves to IDLE. No grant happens in GAP.
- If s2 changed during SEND, then after acceptance shadow ≠ s2, so pend re-arms and the newer byte is sent later. No change is lost; intermediate values may be coalesced.
- tx_valid never deasserts without acceptance.

## Timing
- Reset values: tx_valid=0, tx_data=8'h00, tx_tag=0, frames_sent=0, FSM=IDLE, shadows=00, hb flags=0, heartbeat counter=0, sync flops=00.
- Input-to-offer latency with FSM idle and no contention:
  - The new value is captured at edge E0 into s1 and at E1 into s2.
  - The grant happens at E2, and tx_valid is high after E2.
- Acceptance at edge Ea: tx_valid is low after Ea. The earliest next tx_valid rise is at edge Ea+GAP_CYCLES+1 (Ea+1 when GAP_CYCLES=0).
- A heartbeat tick on the same edge as an acceptance for X: the tick wins, so hb_X stays set.
- A change and a heartbeat for the same player produce one frame only.
- Reset asserted mid-SEND: tx_valid drops immediately (asynchronously). No partial counter update occurs.

## Test plan
- Post-reset, p0=8'h05, p1=8'h05, tx_ready=1, GAP_CYCLES=2:
  - Frame tag0/05 is offered 3 edges after rst deasserts.
  - Frame tag1/05 follows after a 2-cycle gap.
  - frames_sent=2. Nothing further is sent until the heartbeat.
- Backpressure: with tx_ready=0 for 50 cycles while p0 goes 05→06→07:
  - tx_data stays 05 and tag0 is held.
  - After tx_ready=1 and the gap, one more frame 07 is sent. The value 06 is never sent.
- Urgent preempt: both players pending, rr_ptr=0, p1=8'h85 → the tag1/85 frame is granted first.
- Round-robin: both players keep changing every frame with tx_ready=1 → tags strictly alternate 0,1,0,1 over 8 frames.
- Heartbeat: HEARTBEAT_CYCLES=100, inputs static → one frame per player per 100 cycles, with identical data.
- Async reset during SEND → tx_valid=0 and frames_sent=0 immediately, before the next clk edge.
